load_store_unit: RTL

Sits directly upstream of the word-addressed main memory, between the core's execute stage and that memory.
- Accepts byte, halfword and word load/store requests using byte addresses.
- Translates each request into word-index memory accesses.
- Performs read-modify-write for sub-word stores and sign or zero extension for loads.
- Returns one response per request over a valid/ready handshake.
- Faults on misaligned, out-of-range or illegal-size requests without touching memory.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_mux.sv | 42 ++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane
// merge of new store data into an existing word for sub-word stores.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  lsu_size_e   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        merged    = new_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged    = word;
                merged[{lane, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged    = word;
                merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_data = word;
                merged    = new_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory: fault
// screening, read-modify-write for sub-word stores, extended loads.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory read issued (loads and sub-word stores)
// DATA  | read data returned; extract load lane or merge store lane
// WRITE | memory write issued
// RESP  | response held until resp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read_en,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    lsu_state_e  state_q, state_d;
    logic        wr_q;
    lsu_size_e   size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    lsu_size_e   size_in;
    logic        accept;
    logic        req_fault;
    logic        req_word_store;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign size_in        = lsu_size_e'(req_size);
    assign accept         = req_valid && (state_q == ST_IDLE);
    assign req_word_store = req_write && (size_in == SZ_WORD);
    assign req_fault      = (size_in == SZ_ILLEGAL)
                         || ((size_in == SZ_HALF) && req_addr[0])
                         || ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00))
                         || (req_addr[31:2] >= DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_fault)           state_d = ST_RESP;
                    else if (req_word_store) state_d = ST_WRITE;
                    else                     state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_DATA;
            ST_DATA:  state_d = wr_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    lsu_lane_mux u_lane_mux (
        .word        (mem_read_data),
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .new_data    (wdata_q),
        .load_data   (lane_load),
        .merged      (lane_merged)
    );

    // Memory addresses only move when the matching access is about to
    // start, so they hold their last value while the enables are low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q           <= 1'b0;
            size_q         <= SZ_BYTE;
            uns_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            fault_q        <= 1'b0;
            rdata_q        <= '0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            size_q  <= size_in;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            rdata_q <= '0;
            if (!req_fault) begin
                if (req_word_store) begin
                    mem_write_addr <= {2'b00, req_addr[31:2]};
                    mem_write_data <= req_wdata;
                end else begin
                    mem_read_addr  <= {2'b00, req_addr[31:2]};
                end
            end
        end else if (state_q == ST_DATA) begin
            if (wr_q) begin
                mem_write_addr <= {2'b00, addr_q[31:2]};
                mem_write_data <= lane_merged;
            end else begin
                rdata_q <= lane_load;
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rdata   = resp_valid ? rdata_q : '0;
    assign resp_fault   = resp_valid && fault_q;
    assign mem_read_en  = (state_q == ST_READ);
    assign mem_write_en = (state_q == ST_WRITE);

endmodule
